// File: rtl/lab8_soc_led_pulse_out.sv
// LED/GPIO output port for the lab8 SoC.
// A static DATA register (with atomic set/clear aliases) is ORed with a
// retriggerable one-shot pulse mask that is held for PULSE_LEN clocks.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no pulse running, count = 0, mask = 0
// S_ACTIVE | pulse running, mask overlaid on out_port, count > 0
module lab8_soc_led_pulse_out #(
    parameter int                     DATA_WIDTH      = 8,
    parameter int                     COUNT_WIDTH     = 16,
    parameter logic [DATA_WIDTH-1:0]  RESET_VALUE     = '0,
    parameter logic [COUNT_WIDTH-1:0] RESET_PULSE_LEN = COUNT_WIDTH'(1000)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
    localparam logic [2:0] ADDR_PULSE     = 3'd2;
    localparam logic [2:0] ADDR_STATUS    = 3'd3;
    localparam logic [2:0] ADDR_OUTSET    = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_e;

    state_e                 state_q,     state_d;
    logic [DATA_WIDTH-1:0]  data_q,      data_d;
    logic [COUNT_WIDTH-1:0] pulse_len_q, pulse_len_d;
    logic [DATA_WIDTH-1:0]  mask_q,      mask_d;
    logic [COUNT_WIDTH-1:0] count_q,     count_d;
    logic                   done_q,      done_d;
    logic                   irq_en_q,    irq_en_d;
    logic [31:0]            readdata_q,  readdata_d;

    logic wr_en;
    logic pulse_wr;
    logic status_wr;
    logic done_set;
    logic busy;
    logic unused_wd;

    assign wr_en     = chipselect & ~write_n;
    assign pulse_wr  = wr_en && (address == ADDR_PULSE);
    assign status_wr = wr_en && (address == ADDR_STATUS);
    assign busy      = (count_q != '0);
    // Only some writedata bits are meaningful for any given register.
    assign unused_wd = ^writedata;

    // Pulse sequencer: start, retrigger, abort and natural expiry.
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        count_d  = count_q;
        done_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pulse_wr && (pulse_len_q != '0)) begin
                    mask_d  = writedata[DATA_WIDTH-1:0];
                    count_d = pulse_len_q;
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (pulse_wr) begin
                    // A write always wins over expiry, so a retrigger on the
                    // last cycle never reports done.
                    if (pulse_len_q != '0) begin
                        mask_d  = writedata[DATA_WIDTH-1:0];
                        count_d = pulse_len_q;
                    end else begin
                        mask_d  = '0;
                        count_d = '0;
                        state_d = S_IDLE;
                    end
                end else if (count_q == COUNT_WIDTH'(1)) begin
                    mask_d   = '0;
                    count_d  = '0;
                    done_set = 1'b1;
                    state_d  = S_IDLE;
                end else if (count_q != '0) begin
                    count_d = count_q - COUNT_WIDTH'(1);
                end
            end
            default: begin
                mask_d  = '0;
                count_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Register-file writes: DATA with set/clear aliases, PULSE_LEN, STATUS.
    always_comb begin
        data_d      = data_q;
        pulse_len_d = pulse_len_q;
        irq_en_d    = irq_en_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:      data_d      = writedata[DATA_WIDTH-1:0];
                ADDR_PULSE_LEN: pulse_len_d = writedata[COUNT_WIDTH-1:0];
                ADDR_STATUS:    irq_en_d    = writedata[2];
                ADDR_OUTSET:    data_d      = data_q | writedata[DATA_WIDTH-1:0];
                ADDR_OUTCLEAR:  data_d      = data_q & ~writedata[DATA_WIDTH-1:0];
                default:        ;
            endcase
        end
        // Expiry beats a same-cycle write-1-to-clear.
        done_d = done_set | (done_q & ~(status_wr & writedata[1]));
    end

    // Read mux, sampled every edge from pre-write register state.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:      readdata_d[DATA_WIDTH-1:0]  = data_q;
            ADDR_PULSE_LEN: readdata_d[COUNT_WIDTH-1:0] = pulse_len_q;
            ADDR_PULSE:     readdata_d[DATA_WIDTH-1:0]  = mask_q;
            ADDR_STATUS: begin
                readdata_d[0]                = busy;
                readdata_d[1]                = done_q;
                readdata_d[2]                = irq_en_q;
                readdata_d[16 +: COUNT_WIDTH] = count_q;
            end
            default:        readdata_d = '0;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            data_q      <= RESET_VALUE;
            pulse_len_q <= RESET_PULSE_LEN;
            mask_q      <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            readdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            pulse_len_q <= pulse_len_d;
            mask_q      <= mask_d;
            count_q     <= count_d;
            done_q      <= done_d;
            irq_en_q    <= irq_en_d;
            readdata_q  <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign out_port = data_q | mask_q;
    assign irq      = done_q & irq_en_q;

endmodule

// File: doc/lab8_soc_led_pulse_out.md
Name: lab8_soc_led_pulse_out

Overview:
- Avalon-MM slave that drives an LED/GPIO output bus from the Nios II. It is the write-side counterpart of the SoC's button input PIO.
- Holds a static output data register with atomic set/clear aliases.
- Also holds a retriggerable one-shot pulse overlay: a masked set of bits is forced high for a programmed number of clocks.
- Sits on the lab8_soc system interconnect. `out_port` goes to top-level LEDs, and `irq` goes to the CPU interrupt controller.

Parameters:
- DATA_WIDTH, 8, width of `out_port` and of all mask/data registers.
- COUNT_WIDTH, 16, width of the pulse length and countdown registers.
- RESET_VALUE, 0, reset value of the DATA register.
- RESET_PULSE_LEN, 1000, reset value of the PULSE_LEN register.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  write data.
- readdata  out  32  registered read data, zero-extended.
- out_port  out  DATA_WIDTH  LED/GPIO output.
- irq  out  1  level interrupt.

Behaviour:
- Register map; fields are truncated on write and zero-extended on read:
  - 0 DATA: RW.
  - 1 PULSE_LEN: RW, COUNT_WIDTH bits.
  - 2 PULSE: write starts a pulse; read returns the active pulse mask.
  - 3 STATUS:
    - bit0 busy (RO).
    - bit1 done (sticky, write 1 to clear).
    - bit2 irq_en (RW).
    - bits[16+COUNT_WIDTH-1:16] remaining count (RO).
  - 4 OUTSET: WO; DATA <= DATA | wd.
  - 5 OUTCLEAR: WO; DATA <= DATA & ~wd.
  - 6, 7: read 0, writes ignored.
  - OUTSET and OUTCLEAR read 0.
- Reset (reset_n=0 at a clk edge):
  - DATA=RESET_VALUE, PULSE_LEN=RESET_PULSE_LEN.
  - mask=0, count=0, done=0, irq_en=0.
  - readdata=0, out_port=RESET_VALUE, irq=0.
  - Reset during an active pulse aborts it and does not set done.
- Read:
  - readdata <= mux(address) on every clk edge. There is no read strobe; chipselect is ignored for reads.
  - Latency is 1 clk: the value reflects register state before any same-cycle write.
- Write: takes effect at the clk edge where chipselect=1 and write_n=0. There are no wait states.
- out_port = DATA | mask. Both are registers, so the output is glitch-free. Output changes are visible 1 clk after the write edge.
- Pulse FSM, states IDLE (count=0) and ACTIVE (count>0):
  - IDLE, write PULSE with PULSE_LEN>0: mask <= wd[DATA_WIDTH-1:0], count <= PULSE_LEN, go to ACTIVE.
  - IDLE, write PULSE with PULSE_LEN=0: no effect.
  - ACTIVE: count decrements by 1 each clk, so the mask is visible on out_port for exactly PULSE_LEN cycles.
  - ACTIVE, count=1 with no retrigger: next edge sets count=0, mask=0, done=1, go to IDLE.
  - ACTIVE, write PULSE with PULSE_LEN>0 (retrigger): reload mask and count; done is not set. This holds even if count=1 in the same cycle.
  - ACTIVE, write PULSE with PULSE_LEN=0: abort; mask=0, count=0, done not set.
  - Writing PULSE_LEN while ACTIVE affects only the next pulse.
  - A pulse mask of 0 still runs the timer and sets done.
- busy = (count != 0).
- done:
  - A set event (natural expiry) and a same-cycle W1C write: set wins.
  - A STATUS write with bit1=0 leaves done unchanged.
  - A STATUS write updates irq_en from bit2.
- irq = done & irq_en, registered from the flops with no extra delay.
- DATA writes during a pulse change only the DATA component; the overlaid mask bits stay high.
- Count never wraps: decrement occurs only when count>0.

Test Plan:
- Reset → write DATA=0xA5, then read addr 0 → out_port=0xA5 one clk after the write; readdata=0x000000A5 one clk after address is presented.
- DATA=0xA5, write OUTSET=0x0F, then OUTCLEAR=0x81 → out_port 0xAF, then 0x2E; read of addr 4 returns 0.
- PULSE_LEN=5, DATA=0x00, write PULSE=0x30 → out_port=0x30 for exactly 5 clks, then 0x00. STATUS busy is 1 during the pulse, then STATUS=0x2. With irq_en=1, irq rises on the same edge as the 0x00 output.
- Retrigger: PULSE_LEN=4; pulse 0x01, then at the edge where count=1 write PULSE=0x02 → out_port 0x02 for 4 more clks; done is set only at the final expiry.
- W1C collision: irq_en=1, done=0; a STATUS write of 0x6 on the expiry edge → done=1 and irq stays 1. A later write of 0x6 → done=0, irq=0.
- Reset mid-pulse (count=3) → out_port=RESET_VALUE next edge, STATUS=0, irq=0. A PULSE write with PULSE_LEN=0 leaves out_port unchanged.
